// File: rtl/serial_logic_unit_pkg.sv
// rtl/serial_logic_unit_pkg.sv - opcode constants and FSM state type for the serial logic unit
package alu_logic_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
    localparam logic [OP_W-1:0] OP_AND  = 3'b001;
    localparam logic [OP_W-1:0] OP_OR   = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/serial_logic_unit_if.sv
// rtl/serial_logic_unit_if.sv - start/operand/result bundle between requester and logic unit
interface serial_logic_unit_if import alu_logic_pkg::*; #(
    parameter int WIDTH = 32
) ();
    logic             ctrl_start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] data_A;
    logic [WIDTH-1:0] data_B;
    logic             busy;
    logic             data_resultRDY;
    logic [WIDTH-1:0] data_result;
    logic             zero;

    modport master (
        output ctrl_start, op, data_A, data_B,
        input  busy, data_resultRDY, data_result, zero
    );

    modport slave (
        input  ctrl_start, op, data_A, data_B,
        output busy, data_resultRDY, data_result, zero
    );
endinterface

// File: rtl/serial_logic_unit_logic_slice.sv
// rtl/serial_logic_unit_logic_slice.sv - combinational bitwise op on one SLICE-bit slice
module logic_slice import alu_logic_pkg::*; #(
    parameter int SLICE = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);
    always_comb begin
        y = ~a;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = ~a;
        endcase
    end
endmodule

// File: rtl/serial_logic_unit.sv
// rtl/serial_logic_unit.sv - multi-cycle bitwise logic unit, SLICE bits per cycle
module serial_logic_unit import alu_logic_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    serial_logic_unit_if.slave  bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d, res_q, res_d;
    logic             busy_q, busy_d, rdy_q, rdy_d, zero_q, zero_d;

    logic [IW-1:0]    base;
    logic [SLICE-1:0] slice_y;
    logic [WIDTH-1:0] work_next;

    // When SLICE == WIDTH the cast folds SLICE to 0, harmless since the counter is always 0.
    assign base = IW'(cnt_q) * IW'(SLICE);

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op (op_q),
        .a  (a_q[base +: SLICE]),
        .b  (b_q[base +: SLICE]),
        .y  (slice_y)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        res_d     = res_q;
        busy_d    = busy_q;
        rdy_d     = 1'b0;
        zero_d    = zero_q;
        work_next = work_q;
        work_next[base +: SLICE] = slice_y;

        case (state_q)
            ST_IDLE: begin
                if (bus.ctrl_start) begin
                    a_d     = bus.data_A;
                    b_d     = bus.data_B;
                    op_d    = bus.op;
                    work_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = work_next;
                if (cnt_q == LAST) begin
                    res_d   = work_next;
                    zero_d  = (work_next == '0);
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.data_result    = res_q;
    assign bus.zero           = zero_q;
endmodule

// File: tb/tb_serial_logic_unit.sv
// tb/tb_serial_logic_unit.sv - randomized and directed bench against a behavioural op/latency model
module tb_serial_logic_unit;
    import alu_logic_pkg::*;

    localparam int W1 = 32, S1 = 8,  N1 = W1 / S1;
    localparam int W2 = 16, S2 = 16, N2 = W2 / S2;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    bit   chk_en  = 1'b0;
    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;

    serial_logic_unit_if #(.WIDTH(W1)) bus1 ();
    serial_logic_unit_if #(.WIDTH(W2)) bus2 ();

    serial_logic_unit #(.WIDTH(W1), .SLICE(S1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
    serial_logic_unit #(.WIDTH(W2), .SLICE(S2)) dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model: an accepted start occupies the unit for N edges, result appears on the last one.
    int          m1_rem = 0, m2_rem = 0;
    logic [2:0]  m1_op, m2_op;
    logic [31:0] m1_a, m1_b, m1_res = '0;
    logic [15:0] m2_a, m2_b, m2_res = '0;
    logic        m1_rdy = 1'b0, m1_zero = 1'b1, m2_rdy = 1'b0, m2_zero = 1'b1;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m1_rem <= 0; m1_rdy <= 1'b0; m1_res <= '0; m1_zero <= 1'b1;
        end else begin
            m1_rdy <= 1'b0;
            if (m1_rem == 0) begin
                if (bus1.ctrl_start) begin
                    m1_op <= bus1.op; m1_a <= bus1.data_A; m1_b <= bus1.data_B; m1_rem <= N1;
                end
            end else begin
                m1_rem <= m1_rem - 1;
                if (m1_rem == 1) begin
                    m1_res  <= ref_op(m1_op, m1_a, m1_b);
                    m1_zero <= (ref_op(m1_op, m1_a, m1_b) == 32'd0);
                    m1_rdy  <= 1'b1;
                end
            end
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m2_rem <= 0; m2_rdy <= 1'b0; m2_res <= '0; m2_zero <= 1'b1;
        end else begin
            m2_rdy <= 1'b0;
            if (m2_rem == 0) begin
                if (bus2.ctrl_start) begin
                    m2_op <= bus2.op; m2_a <= bus2.data_A; m2_b <= bus2.data_B; m2_rem <= N2;
                end
            end else begin
                m2_rem <= m2_rem - 1;
                if (m2_rem == 1) begin
                    m2_res  <= 16'(ref_op(m2_op, {16'd0, m2_a}, {16'd0, m2_b}));
                    m2_zero <= (16'(ref_op(m2_op, {16'd0, m2_a}, {16'd0, m2_b})) == 16'd0);
                    m2_rdy  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy1", bus1.busy, m1_rem != 0);
            check("rdy1", bus1.data_resultRDY, m1_rdy);
            check("result1", bus1.data_result, m1_res);
            check("zero1", bus1.zero, m1_zero);
            check("busy2", bus2.busy, m2_rem != 0);
            check("rdy2", bus2.data_resultRDY, m2_rdy);
            check("result2", bus2.data_result, m2_res);
            check("zero2", bus2.zero, m2_zero);
        end
    end

    logic [31:0] exp_ops [1:7] = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'hFF0F_EDCB,
                                   32'h000F_0000, 32'h00FF_1234, 32'hF0F0_1234};

    task automatic run1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit disturb, input string nm);
        int lat;
        int pulses;
        bit seen;
        @(negedge clock);
        bus1.ctrl_start = 1'b1; bus1.op = op; bus1.data_A = a; bus1.data_B = b;
        @(posedge clock);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clock);
            if (bus1.data_resultRDY) begin
                seen = 1'b1;
                bus1.ctrl_start = 1'b0;
            end else begin
                bus1.ctrl_start = disturb;
                bus1.op     = 3'($urandom);
                bus1.data_A = $urandom;
                bus1.data_B = $urandom;
                lat++;
            end
        end
        check({nm, " latency"}, lat, N1);
        check({nm, " result"}, bus1.data_result, exp);
        check({nm, " zero"}, bus1.zero, exp == 32'd0);
        pulses = 0;
        repeat (N1 + 2) begin
            @(negedge clock);
            if (bus1.data_resultRDY) pulses++;
        end
        check({nm, " extra rdy"}, pulses, 0);
    endtask

    task automatic b2b(input bit second, input int n, input string nm);
        int t [3];
        int k;
        k = 0;
        @(negedge clock);
        for (int i = 0; i < 40 && k < 3; i++) begin
            if (second) begin
                bus2.ctrl_start = 1'b1; bus2.op = 3'($urandom);
                bus2.data_A = 16'($urandom); bus2.data_B = 16'($urandom);
            end else begin
                bus1.ctrl_start = 1'b1; bus1.op = 3'($urandom);
                bus1.data_A = $urandom; bus1.data_B = $urandom;
            end
            @(negedge clock);
            if ((second ? bus2.data_resultRDY : bus1.data_resultRDY) == 1'b1) begin
                t[k] = cyc;
                k++;
            end
        end
        bus1.ctrl_start = 1'b0;
        bus2.ctrl_start = 1'b0;
        check({nm, " pulses"}, k, 3);
        if (k == 3) begin
            check({nm, " gap0"}, t[1] - t[0], n + 1);
            check({nm, " gap1"}, t[2] - t[1], n + 1);
        end
        repeat (n + 3) @(negedge clock);
    endtask

    initial begin
        bus1.ctrl_start = 1'b0; bus1.op = '0; bus1.data_A = '0; bus1.data_B = '0;
        bus2.ctrl_start = 1'b0; bus2.op = '0; bus2.data_A = '0; bus2.data_B = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("reset busy", bus1.busy, 1'b0);
        check("reset rdy", bus1.data_resultRDY, 1'b0);
        check("reset result", bus1.data_result, 32'd0);
        check("reset zero", bus1.zero, 1'b1);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        run1(OP_NOT, 32'h0000_00FF, 32'h1234_5678, 32'hFFFF_FF00, 1'b0, "not");
        for (int i = 1; i < 8; i++)
            run1(3'(i), 32'hF0F0_1234, 32'h0FF0_FFFF, exp_ops[i], 1'b0, $sformatf("op%0d", i));
        run1(OP_XOR, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0, "xor zero");
        run1(OP_AND, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 32'h0E0D_B0E0, 1'b1, "busy start");

        // Asynchronous reset two edges into an AND
        @(negedge clock);
        bus1.ctrl_start = 1'b1; bus1.op = OP_AND; bus1.data_A = 32'hFFFF_FFFF; bus1.data_B = 32'h8000_0001;
        @(posedge clock);
        @(negedge clock);
        bus1.ctrl_start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrun busy", bus1.busy, 1'b0);
        check("midrun rdy", bus1.data_resultRDY, 1'b0);
        check("midrun result", bus1.data_result, 32'd0);
        check("midrun zero", bus1.zero, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        begin
            int pulses;
            pulses = 0;
            repeat (N1 + 3) begin
                @(negedge clock);
                if (bus1.data_resultRDY) pulses++;
            end
            check("midrun no rdy", pulses, 0);
        end

        b2b(1'b0, N1, "b2b32");
        b2b(1'b1, N2, "b2b16");

        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            bus1.ctrl_start = 1'($urandom_range(0, 1));
            bus1.op = 3'($urandom); bus1.data_A = $urandom;
            bus1.data_B = ($urandom_range(0, 7) == 0) ? bus1.data_A : $urandom;
            bus2.ctrl_start = 1'($urandom_range(0, 1));
            bus2.op = 3'($urandom); bus2.data_A = 16'($urandom);
            bus2.data_B = ($urandom_range(0, 7) == 0) ? bus2.data_A : 16'($urandom);
        end
        @(negedge clock);
        bus1.ctrl_start = 1'b0;
        bus2.ctrl_start = 1'b0;
        repeat (N1 + 3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
